// File: rtl/dac_clocker_mc_pkg.sv
// Shared definitions for the DAC sample clocker.
// Contents: default widths, rate field type, and the per-channel
// accumulator increment helper (rate scaled by the oversample ratio).
package dac_pkg;

    localparam int RATE_W_DEF  = 16;
    localparam int PHASE_W_DEF = 9;

    typedef logic [RATE_W_DEF-1:0] rate_t;

    // Increment added to the accumulator every clk: rate * 2^phase_w.
    // Widths are bounded so the result always fits in 32 bits; the extra
    // MSB keeps the compare against ck_base unsigned and overflow-free.
    function automatic logic [32:0] mk_targ(input logic [31:0] rate, input int phase_w);
        return {1'b0, rate} << phase_w;
    endfunction

endpackage

// File: rtl/dac_clocker_mc_if.sv
// Sample-fetch handshake bundle between the clocker and the fetch logic.
//   next_sample : one-cycle pulse at each sample boundary (clocker -> fetch)
//   req         : sample request level, held until ack (clocker -> fetch)
//   ovr         : sticky overrun flag (clocker -> fetch)
//   ack         : single-cycle acknowledge of req (fetch -> clocker)
//   ovr_clr     : clears the sticky overrun flag (fetch -> clocker)
interface dac_clocker_mc_if #(
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0] next_sample;
    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] ovr;
    logic [CHANNELS-1:0] ack;
    logic [CHANNELS-1:0] ovr_clr;

    modport master (output next_sample, req, ovr, input ack, ovr_clr);
    modport slave  (input next_sample, req, ovr, output ack, ovr_clr);
endinterface

// File: rtl/dac_clk_chan.sv
// One DAC clock channel: fractional accumulator, oversample phase,
// shadow sample rate and the sample request / overrun bookkeeping.
// Ports:
//   clk, rst     : system clock, async active-low reset
//   ck_base      : clk frequency in Hz
//   rate         : requested sample rate in Hz (shadowed at sample boundaries)
//   en           : channel enable; low holds the channel idle at phase 0
//   ack, ovr_clr : request acknowledge, overrun clear
//   dac_clk      : one-cycle oversample tick
//   phase        : oversample phase counter
//   next_sample  : one-cycle pulse when phase wraps to 0
//   req, ovr     : sample request level, sticky overrun
module dac_clk_chan
    import dac_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int RATE_W  = RATE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        ck_base,
    input  logic [RATE_W-1:0]  rate,
    input  logic               en,
    input  logic               ack,
    input  logic               ovr_clr,
    output logic               dac_clk,
    output logic [PHASE_W-1:0] phase,
    output logic               next_sample,
    output logic               req,
    output logic               ovr
);

    logic [32:0]       acc;
    logic [32:0]       acc_nxt;
    logic [32:0]       targ;
    logic [32:0]       sum;
    logic [32:0]       base;
    logic [RATE_W-1:0] rate_act;
    logic              tick;
    logic              wrap;

    always_comb begin
        base    = {1'b0, ck_base};
        targ    = mk_targ(32'(rate_act), PHASE_W);
        sum     = acc + targ;
        acc_nxt = sum;
        tick    = 1'b0;
        if (ck_base == '0) begin
            acc_nxt = acc;
        end else if (targ >= base) begin
            // Requested tick rate at or above clk: saturate to a tick every cycle.
            tick    = 1'b1;
            acc_nxt = '0;
        end else if (sum >= base) begin
            tick    = 1'b1;
            acc_nxt = sum - base;
        end
        wrap = tick && (phase == '1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc         <= '0;
            rate_act    <= '0;
            phase       <= '0;
            dac_clk     <= 1'b0;
            next_sample <= 1'b0;
            req         <= 1'b0;
        end else if (!en) begin
            acc         <= '0;
            rate_act    <= rate;
            phase       <= '0;
            dac_clk     <= 1'b0;
            next_sample <= 1'b0;
            req         <= 1'b0;
        end else begin
            acc         <= acc_nxt;
            dac_clk     <= tick;
            next_sample <= wrap;
            if (tick) begin
                phase <= phase + PHASE_W'(1);
            end
            // New rate only takes effect from the next sample period onwards.
            if (wrap) begin
                rate_act <= rate;
            end
            // A new sample boundary wins over a same-cycle ack: the fresh
            // request stays pending.
            if (wrap) begin
                req <= 1'b1;
            end else if (ack) begin
                req <= 1'b0;
            end
        end
    end

    // Overrun is kept across disable; set has priority over clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr <= 1'b0;
        end else if (en && wrap && req && !ack) begin
            ovr <= 1'b1;
        end else if (ovr_clr) begin
            ovr <= 1'b0;
        end
    end

endmodule

// File: rtl/dac_clocker_mc.sv
// Multi-channel DAC sample clocker. Each channel derives an oversampled
// tick at rate * 2^PHASE_W from clk using a divider-free accumulator and
// raises a sample request at every sample boundary.
// Ports:
//   clk, rst : system clock, async active-low reset
//   ck_base  : clk frequency in Hz, shared by all channels
//   rate     : per-channel sample rate, channel i at [i*RATE_W +: RATE_W]
//   en       : per-channel enable
//   dac_clk  : per-channel oversample tick
//   phase    : per-channel phase, channel i at [i*PHASE_W +: PHASE_W]
//   fetch    : sample request handshake (next_sample/req/ovr out, ack/ovr_clr in)
module dac_clocker_mc
    import dac_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int PHASE_W  = PHASE_W_DEF,
    parameter int RATE_W   = RATE_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  ck_base,
    input  logic [CHANNELS*RATE_W-1:0]   rate,
    input  logic [CHANNELS-1:0]          en,
    output logic [CHANNELS-1:0]          dac_clk,
    output logic [CHANNELS*PHASE_W-1:0]  phase,
    dac_clocker_mc_if.master             fetch
);

    logic [CHANNELS-1:0] next_sample;
    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] ovr;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        dac_clk_chan #(
            .PHASE_W (PHASE_W),
            .RATE_W  (RATE_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .ck_base     (ck_base),
            .rate        (rate[i*RATE_W +: RATE_W]),
            .en          (en[i]),
            .ack         (fetch.ack[i]),
            .ovr_clr     (fetch.ovr_clr[i]),
            .dac_clk     (dac_clk[i]),
            .phase       (phase[i*PHASE_W +: PHASE_W]),
            .next_sample (next_sample[i]),
            .req         (req[i]),
            .ovr         (ovr[i])
        );
    end

    assign fetch.next_sample = next_sample;
    assign fetch.req         = req;
    assign fetch.ovr         = ovr;

endmodule

// File: tb/tb_dac_clocker_mc.sv
// Self-checking bench for dac_clocker_mc (2 channels, PHASE_W=2).
// A reference model counts ticks as floor(total_increment / ck_base) and
// tracks phase, sample events, request and overrun from those counts.
module tb_dac_clocker_mc;

    localparam int CH  = 2;
    localparam int PW  = 2;
    localparam int RW  = 16;
    localparam int OSR = 1 << PW;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [31:0]      ck_base;
    logic [CH*RW-1:0] rate;
    logic [CH-1:0]    en;
    logic [CH-1:0]    dac_clk;
    logic [CH*PW-1:0] phase;

    dac_clocker_mc_if #(.CHANNELS(CH)) fetch ();

    dac_clocker_mc #(
        .CHANNELS (CH),
        .PHASE_W  (PW),
        .RATE_W   (RW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ck_base (ck_base),
        .rate    (rate),
        .en      (en),
        .dac_clk (dac_clk),
        .phase   (phase),
        .fetch   (fetch)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reference model state
    longint m_sum[CH];
    longint m_ticks[CH];
    int     m_ph[CH];
    int     m_ract[CH];
    bit     m_dck[CH];
    bit     m_ns[CH];
    bit     m_req[CH];
    bit     m_ovr[CH];

    // observed tick statistics
    int cyc;
    int tick_cnt[CH];
    int last_tick[CH];
    int min_iv[CH];
    int max_iv[CH];

    function automatic int rate_of(int c);
        return int'(rate[c*RW +: RW]);
    endfunction

    task automatic set_rate(input int c, input int r);
        rate[c*RW +: RW] = RW'(r);
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_sum[c] = 0; m_ticks[c] = 0; m_ph[c] = 0; m_ract[c] = 0;
            m_dck[c] = 0; m_ns[c] = 0; m_req[c] = 0; m_ovr[c] = 0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            bit     tick;
            bit     wrap;
            longint targ;
            longint base;
            tick = 0;
            base = longint'(ck_base);
            if (!en[c]) begin
                m_sum[c] = 0; m_ticks[c] = 0; m_ph[c] = 0;
                m_dck[c] = 0; m_ns[c] = 0; m_req[c] = 0;
                m_ract[c] = rate_of(c);
                if (fetch.ovr_clr[c]) m_ovr[c] = 0;
            end else begin
                targ = longint'(m_ract[c]) * OSR;
                if (base != 0) begin
                    if (targ >= base) begin
                        tick = 1; m_sum[c] = 0; m_ticks[c] = 0;
                    end else begin
                        m_sum[c] += targ;
                        if (m_sum[c] / base > m_ticks[c]) begin
                            tick = 1; m_ticks[c]++;
                        end
                    end
                end
                wrap = tick && (m_ph[c] == OSR - 1);
                if (tick) m_ph[c] = (m_ph[c] + 1) % OSR;
                if (wrap && m_req[c] && !fetch.ack[c]) m_ovr[c] = 1;
                else if (fetch.ovr_clr[c]) m_ovr[c] = 0;
                if (wrap) m_req[c] = 1;
                else if (fetch.ack[c]) m_req[c] = 0;
                if (wrap) m_ract[c] = rate_of(c);
                m_dck[c] = tick;
                m_ns[c]  = wrap;
            end
        end
    endtask

    task automatic check_outputs();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("ch%0d.dac_clk", c), 32'(dac_clk[c]), 32'(m_dck[c]));
            chk($sformatf("ch%0d.phase", c), 32'(phase[c*PW +: PW]), 32'(m_ph[c]));
            chk($sformatf("ch%0d.next_sample", c), 32'(fetch.next_sample[c]), 32'(m_ns[c]));
            chk($sformatf("ch%0d.req", c), 32'(fetch.req[c]), 32'(m_req[c]));
            chk($sformatf("ch%0d.ovr", c), 32'(fetch.ovr[c]), 32'(m_ovr[c]));
        end
    endtask

    task automatic clr_stats();
        cyc = 0;
        for (int c = 0; c < CH; c++) begin
            tick_cnt[c] = 0; last_tick[c] = -1; min_iv[c] = 1 << 30; max_iv[c] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        check_outputs();
        cyc++;
        for (int c = 0; c < CH; c++) begin
            if (dac_clk[c]) begin
                tick_cnt[c]++;
                if (last_tick[c] >= 0) begin
                    if (cyc - last_tick[c] < min_iv[c]) min_iv[c] = cyc - last_tick[c];
                    if (cyc - last_tick[c] > max_iv[c]) max_iv[c] = cyc - last_tick[c];
                end
                last_tick[c] = cyc;
            end
        end
    endtask

    task automatic wait_ns(input int c, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!fetch.next_sample[c] && n < budget);
        chk($sformatf("ch%0d.ns_seen", c), 32'(fetch.next_sample[c]), 32'd1);
    endtask

    task automatic rand_handshake(input int ack_div, input int clr_div);
        for (int c = 0; c < CH; c++) begin
            fetch.ack[c]     = ($urandom_range(0, ack_div - 1) == 0);
            fetch.ovr_clr[c] = ($urandom_range(0, clr_div - 1) == 0);
        end
    endtask

    int n;
    logic [31:0] rbase;

    initial begin
        ck_base = 32'd1000;
        rate = '0;
        en = '0;
        fetch.ack = '0;
        fetch.ovr_clr = '0;
        model_reset();
        clr_stats();
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("rst.ch%0d.dac_clk", c), 32'(dac_clk[c]), 32'd0);
            chk($sformatf("rst.ch%0d.phase", c), 32'(phase[c*PW +: PW]), 32'd0);
            chk($sformatf("rst.ch%0d.req", c), 32'(fetch.req[c]), 32'd0);
            chk($sformatf("rst.ch%0d.ovr", c), 32'(fetch.ovr[c]), 32'd0);
        end
        rst = 1'b1;

        // long-run rate accuracy: ch0 rate 50 (targ 200), ch1 rate 30 (targ 120)
        set_rate(0, 50);
        set_rate(1, 30);
        step();
        en = 2'b11;
        clr_stats();
        repeat (10000) begin
            rand_handshake(4, 16);
            step();
        end
        fetch.ack = '0;
        fetch.ovr_clr = '0;
        chk("ch0.tick_count", tick_cnt[0], 2000);
        chk("ch1.tick_count", tick_cnt[1], 1200);
        chk("ch0.min_interval", min_iv[0], 5);
        chk("ch0.max_interval", max_iv[0], 5);
        chk("ch1.min_interval", min_iv[1], 8);
        chk("ch1.max_interval", max_iv[1], 9);

        // mid-sample rate change on ch0: 50 -> 100
        wait_ns(0, 100, n);
        repeat (7) step();
        set_rate(0, 100);
        wait_ns(0, 100, n);
        chk("ch0.period_at_change", n + 7, 20);
        wait_ns(0, 100, n);
        chk("ch0.period_after_change", n, 10);

        // restart ch0 at rate 50 with overrun cleared
        en[0] = 1'b0;
        set_rate(0, 50);
        fetch.ovr_clr[0] = 1'b1;
        step();
        fetch.ovr_clr[0] = 1'b0;
        en[0] = 1'b1;
        wait_ns(0, 40, n);
        chk("ch0.first_sample", n, 20);
        chk("ch0.req_first", 32'(fetch.req[0]), 32'd1);
        wait_ns(0, 40, n);
        chk("ch0.ovr_set", 32'(fetch.ovr[0]), 32'd1);
        chk("ch0.req_held", 32'(fetch.req[0]), 32'd1);
        fetch.ovr_clr[0] = 1'b1;
        step();
        fetch.ovr_clr[0] = 1'b0;
        chk("ch0.ovr_cleared", 32'(fetch.ovr[0]), 32'd0);
        repeat (18) step();
        fetch.ovr_clr[0] = 1'b1;
        step();
        fetch.ovr_clr[0] = 1'b0;
        chk("ch0.ns_with_clr", 32'(fetch.next_sample[0]), 32'd1);
        chk("ch0.set_beats_clr", 32'(fetch.ovr[0]), 32'd1);
        fetch.ovr_clr[0] = 1'b1;
        step();
        fetch.ovr_clr[0] = 1'b0;
        repeat (18) step();
        fetch.ack[0] = 1'b1;
        step();
        fetch.ack[0] = 1'b0;
        chk("ch0.ns_with_ack", 32'(fetch.next_sample[0]), 32'd1);
        chk("ch0.req_after_coincident_ack", 32'(fetch.req[0]), 32'd1);
        chk("ch0.no_ovr_coincident_ack", 32'(fetch.ovr[0]), 32'd0);
        fetch.ack[0] = 1'b1;
        step();
        fetch.ack[0] = 1'b0;
        chk("ch0.req_dropped", 32'(fetch.req[0]), 32'd0);

        // clamp: rate 300 -> targ 1200 >= 1000
        en[0] = 1'b0;
        set_rate(0, 300);
        step();
        en[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("ch0.clamp_tick", 32'(dac_clk[0]), 32'd1);
            chk("ch0.clamp_ns", 32'(fetch.next_sample[0]), 32'((i % 4) == 3));
        end

        // ch1 disable/re-enable while ch0 keeps running
        en[1] = 1'b0;
        step();
        chk("ch1.off_phase", 32'(phase[PW +: PW]), 32'd0);
        chk("ch1.off_req", 32'(fetch.req[1]), 32'd0);
        chk("ch0.runs_while_ch1_off", 32'(dac_clk[0]), 32'd1);
        repeat (5) step();
        en[1] = 1'b1;
        repeat (30) step();

        // asynchronous reset mid-run
        repeat (7) step();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("async_rst.ch%0d.dac_clk", c), 32'(dac_clk[c]), 32'd0);
            chk($sformatf("async_rst.ch%0d.phase", c), 32'(phase[c*PW +: PW]), 32'd0);
            chk($sformatf("async_rst.ch%0d.ns", c), 32'(fetch.next_sample[c]), 32'd0);
            chk($sformatf("async_rst.ch%0d.req", c), 32'(fetch.req[c]), 32'd0);
            chk($sformatf("async_rst.ch%0d.ovr", c), 32'(fetch.ovr[c]), 32'd0);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;

        // randomized run with a fixed random ck_base
        rbase = $urandom_range(200, 4000);
        ck_base = rbase;
        en = '0;
        set_rate(0, $urandom_range(1, 1200));
        set_rate(1, $urandom_range(1, 1200));
        step();
        en = 2'b11;
        for (int i = 0; i < 3000; i++) begin
            rand_handshake(3, 20);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 49) == 0) set_rate(c, $urandom_range(1, 1200));
                if ($urandom_range(0, 199) == 0) en[c] = ~en[c];
            end
            ck_base = (i >= 1500 && i < 1510) ? 32'd0 : rbase;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dac_clocker_mc.md
# dac_clocker_mc

Multi-channel, parametrised DAC sample clocker. For each of CHANNELS outputs it derives an oversampled DAC clock enable at rate × 2^PHASE_W from the system clock. It tracks the oversample phase and issues a per-channel sample-request handshake to the sample fetch logic, with overrun detection. It replaces the single-channel divider-based clocker with an exact divider-free fractional accumulator, glitch-free rate changes and per-channel enables.

## Interface
Parameters:
- CHANNELS, 2, number of independent channels (1–8)
- PHASE_W, 9, oversample phase width; oversample ratio = 2^PHASE_W; RATE_W+PHASE_W ≤ 32
- RATE_W, 16, sample-rate field width in Hz

Ports:
- clk  in  1  system clock; sole clock
- rst  in  1  reset, asynchronous assert, active-low
- ck_base  in  32  clk frequency in Hz; shared by all channels
- rate  in  CHANNELS*RATE_W  per-channel sample rate in Hz, channel i at [i*RATE_W +: RATE_W]
- en  in  CHANNELS  per-channel enable
- ack  in  CHANNELS  sample-request acknowledge, single-cycle pulse
- ovr_clr  in  CHANNELS  clears sticky overrun flag
- dac_clk  out  CHANNELS  one-cycle oversample tick
- phase  out  CHANNELS*PHASE_W  current oversample phase
- next_sample  out  CHANNELS  one-cycle pulse at sample boundary
- req  out  CHANNELS  sample request, level, held until ack
- ovr  out  CHANNELS  sticky overrun

## Operation
- Per channel: targ = rate_act << PHASE_W, zero-extended to 33 bits; acc is 33 bits; s = acc + targ.
- If en=1, ck_base≠0 and s ≥ ck_base: acc ← s − ck_base, dac_clk ← 1, phase ← phase+1 (wraps mod 2^PHASE_W). Otherwise acc ← s, dac_clk ← 0.
- Clamp: if targ ≥ ck_base, dac_clk is high every cycle and acc ← 0. There is no error flag.
- ck_base = 0: acc holds and no ticks are issued.
- next_sample ← 1 in the same update where phase wraps from 2^PHASE_W−1 to 0. It is always coincident with dac_clk.
- rate_act is a shadow of rate. It loads on the next_sample event and on every cycle while en=0. Mid-sample rate changes never alter the current sample period.
- req handshake:
  - A next_sample event sets req.
  - ack while req=1 clears req on the next edge.
  - ack with req=0 is ignored.
- Overrun: a next_sample event while req=1 and ack=0 sets ovr; req stays 1.
- A next_sample event in the same cycle as ack: req stays 1, no overrun.
- ovr clears only via ovr_clr. If ovr_clr and an overrun occur in the same cycle, the set wins.
- en=0 clears acc, phase, dac_clk, next_sample and req on the next edge. ovr is held. Re-enable restarts from acc=0, phase=0.

## Timing
- All outputs are registered. The reset value of every output and of acc/rate_act is 0.
- Reset is asynchronous. Mid-operation assertion zeroes the state immediately. After release, the first tick is possible on the first edge.
- Tick latency: dac_clk is high in the cycle after the edge at which s ≥ ck_base was evaluated.
- Period:
  - The average tick interval is ck_base/targ clocks, exact over the long term with zero drift.
  - Jitter is at most 1 clk.
- req rises in the same cycle as next_sample and falls the cycle after ack.
- en and rate are used as synchronous to clk; no internal synchronisers.

## Structure
- Shared package dac_pkg:
  - Localparams RATE_W_DEF=16 and PHASE_W_DEF=9.
  - Typedef rate_t = logic [RATE_W-1:0].
  - Function mk_targ(rate, phase_w) returning the 33-bit increment.
- Sub-module dac_clk_chan holds one channel: accumulator, phase, shadow rate, req/ovr logic. The top generates CHANNELS instances and packs/unpacks the buses.
- No multiplier or divider beyond the constant shift.

## Test plan
- ck_base=1000, PHASE_W=2, rate=50 (targ=200) → dac_clk every 5 clk exactly; next_sample every 20 clk; phase sequence 1,2,3,0.
- ck_base=1000, rate=30 (targ=120), 10000 clk → exactly 1200 dac_clk pulses; intervals only 8 or 9 clk.
- rate 50→100 written mid-sample → current sample still 20 clk; following samples 10 clk.
- Never ack → second next_sample sets ovr, req stays 1; ovr_clr clears ovr. ack coincident with next_sample → req stays 1, no ovr.
- rate=300, PHASE_W=2, ck_base=1000 (targ 1200 ≥ base) → dac_clk every cycle; next_sample every 4 clk.
- Async reset mid-run and en toggle on channel 1 → all outputs 0 immediately; channel 0 unaffected by channel 1's en; channel 1 resumes from phase 0.
